// File: rtl/ee354_param_calculator_if.sv
// Switch/button/result bundle between the board top and the calculator core.
// master: the side driving switches and buttons; slave: the calculator core.
interface ee354_param_calculator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] In;
    logic             ButU;
    logic             ButD;
    logic             ButL;
    logic             ButR;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] R;
    logic             Flag;
    logic             Done;
    logic             QI;
    logic             QGet_A;
    logic             QGet_B;
    logic             QGet_Op;
    logic             QAdd;
    logic             QSub;
    logic             QMul;
    logic             QDiv;
    logic             QErr;
    logic             QDone;

    modport master (
        output In, ButU, ButD, ButL, ButR,
        input  C, R, Flag, Done,
        input  QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone
    );

    modport slave (
        input  In, ButU, ButD, ButL, ButR,
        output C, R, Flag, Done,
        output QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone
    );
endinterface

// File: rtl/ee354_param_calculator.sv
// Parametrised sequential calculator core. Operands and opcode are stepped in
// from the switch bus by debounced button pulses; add/sub finish in one cycle,
// mul (shift-add) and div (restoring) take WIDTH cycles. A result can be
// chained back in as the next operand A.
module ee354_param_calculator #(
    parameter int WIDTH = 16,
    parameter int CW    = 6
) (
    input  logic                          board_clk,
    input  logic                          Reset,
    ee354_param_calculator_if.slave       bus
);

    // One-hot encoding so every state LED is driven straight from a flop.
    typedef enum logic [9:0] {
        S_I      = 10'b00_0000_0001,
        S_GET_A  = 10'b00_0000_0010,
        S_GET_B  = 10'b00_0000_0100,
        S_GET_OP = 10'b00_0000_1000,
        S_ADD    = 10'b00_0001_0000,
        S_SUB    = 10'b00_0010_0000,
        S_MUL    = 10'b00_0100_0000,
        S_DIV    = 10'b00_1000_0000,
        S_ERR    = 10'b01_0000_0000,
        S_DONE   = 10'b10_0000_0000
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [WIDTH-1:0]     b_q,      b_d;
    logic [1:0]           op_q,     op_d;
    logic [WIDTH-1:0]     c_q,      c_d;
    logic [WIDTH-1:0]     r_q,      r_d;
    logic                 flag_q,   flag_d;
    logic                 done_q,   done_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    // Multiply partials: accumulator, left-shifting multiplicand, right-shifting multiplier.
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    // Divide partials: partial remainder, quotient, left-shifting dividend.
    logic [WIDTH-1:0]     rem_q,    rem_d;
    logic [WIDTH-1:0]     quo_q,    quo_d;
    logic [WIDTH-1:0]     dvd_q,    dvd_d;

    // Prioritised button strobes: only the highest-priority pulse survives.
    logic btn_l_s, btn_u_s, btn_r_s, btn_d_s;
    assign btn_l_s = bus.ButL;
    assign btn_u_s = bus.ButU & ~bus.ButL;
    assign btn_r_s = bus.ButR & ~bus.ButL & ~bus.ButU;
    assign btn_d_s = bus.ButD & ~bus.ButL & ~bus.ButU & ~bus.ButR;

    // Shared add/sub datapath; the latched opcode bit 0 selects subtract.
    logic [WIDTH:0]       addsub_s;
    logic [WIDTH-1:0]     b_eff_s;
    logic                 addsub_flag_s;
    // One shift-add step.
    logic [2*WIDTH-1:0]   acc_next_s;
    // One restoring-division step.
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       rem_try_s;
    logic                 q_bit_s;
    logic [WIDTH-1:0]     rem_next_s;
    logic [WIDTH-1:0]     quo_next_s;

    // Arithmetic step values used by the FSM below.
    always_comb begin
        b_eff_s       = op_q[0] ? ~b_q : b_q;
        addsub_s      = {1'b0, a_q} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, op_q[0]};
        // For subtract the carry out is the inverted borrow, so A<B is ~carry.
        addsub_flag_s = op_q[0] ? ~addsub_s[WIDTH] : addsub_s[WIDTH];

        acc_next_s    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

        rem_sh_s      = {rem_q, dvd_q[WIDTH-1]};
        rem_try_s     = rem_sh_s - {1'b0, b_q};
        q_bit_s       = ~rem_try_s[WIDTH];
        rem_next_s    = q_bit_s ? rem_try_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
        quo_next_s    = {quo_q[WIDTH-2:0], q_bit_s};
    end

    // Next-state and datapath register update decisions.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        c_d      = c_q;
        r_d      = r_q;
        flag_d   = flag_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvd_d    = dvd_q;

        case (state_q)
            S_I: begin
                if (btn_u_s) begin
                    state_d = S_GET_A;
                    c_d     = {WIDTH{1'b0}};
                    r_d     = {WIDTH{1'b0}};
                    flag_d  = 1'b0;
                end else begin
                    state_d = S_I;
                end
            end
            S_GET_A: begin
                if (btn_l_s) begin
                    state_d = S_I;
                end else if (btn_r_s) begin
                    a_d     = bus.In;
                    state_d = S_GET_B;
                end else begin
                    state_d = S_GET_A;
                end
            end
            S_GET_B: begin
                if (btn_l_s) begin
                    state_d = S_I;
                end else if (btn_r_s) begin
                    b_d     = bus.In;
                    state_d = S_GET_OP;
                end else if (btn_d_s) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_GET_B;
                end
            end
            S_GET_OP: begin
                if (btn_l_s) begin
                    state_d = S_I;
                end else if (btn_r_s) begin
                    op_d = bus.In[1:0];
                    case (bus.In[1:0])
                        2'b00: state_d = S_ADD;
                        2'b01: state_d = S_SUB;
                        2'b10: begin
                            state_d  = S_MUL;
                            cnt_d    = {CW{1'b0}};
                            acc_d    = {(2*WIDTH){1'b0}};
                            mcand_d  = {{WIDTH{1'b0}}, a_q};
                            mplier_d = b_q;
                        end
                        2'b11: begin
                            if (b_q != {WIDTH{1'b0}}) begin
                                state_d = S_DIV;
                                cnt_d   = {CW{1'b0}};
                                rem_d   = {WIDTH{1'b0}};
                                quo_d   = {WIDTH{1'b0}};
                                dvd_d   = a_q;
                            end else begin
                                state_d = S_ERR;
                                c_d     = {WIDTH{1'b1}};
                                r_d     = a_q;
                                flag_d  = 1'b1;
                            end
                        end
                        default: state_d = S_I;
                    endcase
                end else if (btn_d_s) begin
                    state_d = S_GET_B;
                end else begin
                    state_d = S_GET_OP;
                end
            end
            S_ADD, S_SUB: begin
                c_d     = addsub_s[WIDTH-1:0];
                flag_d  = addsub_flag_s;
                r_d     = {WIDTH{1'b0}};
                state_d = S_DONE;
            end
            S_MUL: begin
                acc_d    = acc_next_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    c_d     = acc_next_s[WIDTH-1:0];
                    flag_d  = |acc_next_s[2*WIDTH-1:WIDTH];
                    r_d     = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                rem_d = rem_next_s;
                quo_d = quo_next_s;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    c_d     = quo_next_s;
                    r_d     = rem_next_s;
                    flag_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                if (btn_l_s) begin
                    state_d = S_I;
                end else if (btn_u_s) begin
                    a_d     = c_q;
                    state_d = S_GET_B;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                if (btn_l_s) begin
                    state_d = S_I;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_I;
            end
        endcase

        done_d = (state_d == S_DONE) || (state_d == S_ERR);
    end

    // State and datapath registers; Reset clears everything asynchronously.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_I;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 2'b00;
            c_q      <= {WIDTH{1'b0}};
            r_q      <= {WIDTH{1'b0}};
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
            dvd_q    <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            c_q      <= c_d;
            r_q      <= r_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvd_q    <= dvd_d;
        end
    end

    assign bus.C       = c_q;
    assign bus.R       = r_q;
    assign bus.Flag    = flag_q;
    assign bus.Done    = done_q;
    assign bus.QI      = state_q[0];
    assign bus.QGet_A  = state_q[1];
    assign bus.QGet_B  = state_q[2];
    assign bus.QGet_Op = state_q[3];
    assign bus.QAdd    = state_q[4];
    assign bus.QSub    = state_q[5];
    assign bus.QMul    = state_q[6];
    assign bus.QDiv    = state_q[7];
    assign bus.QErr    = state_q[8];
    assign bus.QDone   = state_q[9];

endmodule

// File: tb/tb_ee354_param_calculator.sv
// Directed bench for the calculator core: a 16-bit and an 8-bit instance
// share clock and reset; each step drives buttons then checks outputs.
module tb_ee354_param_calculator;

    localparam logic [9:0] ST_I    = 10'h001;
    localparam logic [9:0] ST_GA   = 10'h002;
    localparam logic [9:0] ST_GB   = 10'h004;
    localparam logic [9:0] ST_GO   = 10'h008;
    localparam logic [9:0] ST_ADD  = 10'h010;
    localparam logic [9:0] ST_SUB  = 10'h020;
    localparam logic [9:0] ST_MUL  = 10'h040;
    localparam logic [9:0] ST_DIV  = 10'h080;
    localparam logic [9:0] ST_ERR  = 10'h100;
    localparam logic [9:0] ST_DONE = 10'h200;

    // Button masks in {L,U,R,D} order.
    localparam logic [3:0] BL = 4'b1000;
    localparam logic [3:0] BU = 4'b0100;
    localparam logic [3:0] BR = 4'b0010;
    localparam logic [3:0] BD = 4'b0001;

    logic board_clk = 1'b0;
    logic Reset     = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 board_clk = ~board_clk;

    ee354_param_calculator_if #(.WIDTH(16)) bus16 ();
    ee354_param_calculator_if #(.WIDTH(8))  bus8 ();

    ee354_param_calculator #(.WIDTH(16), .CW(6)) dut16 (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus16.slave)
    );

    ee354_param_calculator #(.WIDTH(8), .CW(4)) dut8 (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus8.slave)
    );

    function automatic logic [9:0] st16();
        return {bus16.QDone, bus16.QErr, bus16.QDiv, bus16.QMul, bus16.QSub,
                bus16.QAdd, bus16.QGet_Op, bus16.QGet_B, bus16.QGet_A, bus16.QI};
    endfunction

    function automatic logic [9:0] st8();
        return {bus8.QDone, bus8.QErr, bus8.QDiv, bus8.QMul, bus8.QSub,
                bus8.QAdd, bus8.QGet_Op, bus8.QGet_B, bus8.QGet_A, bus8.QI};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic press16(input logic [3:0] lurd, input logic [15:0] v);
        bus16.In = v;
        {bus16.ButL, bus16.ButU, bus16.ButR, bus16.ButD} = lurd;
        tick();
        {bus16.ButL, bus16.ButU, bus16.ButR, bus16.ButD} = 4'b0000;
    endtask

    task automatic press8(input logic [3:0] lurd, input logic [7:0] v);
        bus8.In = v;
        {bus8.ButL, bus8.ButU, bus8.ButR, bus8.ButD} = lurd;
        tick();
        {bus8.ButL, bus8.ButU, bus8.ButR, bus8.ButD} = 4'b0000;
    endtask

    initial begin
        bus16.In = 16'h0000;
        {bus16.ButL, bus16.ButU, bus16.ButR, bus16.ButD} = 4'b0000;
        bus8.In = 8'h00;
        {bus8.ButL, bus8.ButU, bus8.ButR, bus8.ButD} = 4'b0000;

        // Reset state
        #12;
        chk("rst_state16", 32'(st16()), 32'(ST_I));
        chk("rst_c16",     32'(bus16.C), 32'h0);
        chk("rst_r16",     32'(bus16.R), 32'h0);
        chk("rst_flag16",  32'(bus16.Flag), 32'h0);
        chk("rst_done16",  32'(bus16.Done), 32'h0);
        chk("rst_state8",  32'(st8()), 32'(ST_I));
        Reset = 1'b0;

        // Add with carry: FFFF + 0002
        press16(BU, 16'h0000);
        chk("add_ga", 32'(st16()), 32'(ST_GA));
        press16(BR, 16'hFFFF);
        press16(BR, 16'h0002);
        press16(BR, 16'h0000);
        chk("add_state",   32'(st16()), 32'(ST_ADD));
        chk("add_done_lo", 32'(bus16.Done), 32'h0);
        tick();
        chk("add_state_done", 32'(st16()), 32'(ST_DONE));
        chk("add_done",  32'(bus16.Done), 32'h1);
        chk("add_c",     32'(bus16.C), 32'h0001);
        chk("add_flag",  32'(bus16.Flag), 32'h1);
        chk("add_r",     32'(bus16.R), 32'h0);
        press16(BL, 16'h0000);
        chk("ack_state", 32'(st16()), 32'(ST_I));
        chk("ack_c_held", 32'(bus16.C), 32'h0001);
        press16(BU, 16'h0000);
        chk("clr_c",    32'(bus16.C), 32'h0);
        chk("clr_flag", 32'(bus16.Flag), 32'h0);

        // Division 100 / 7
        press16(BR, 16'd100);
        press16(BR, 16'd7);
        press16(BR, 16'h0003);
        chk("div_state", 32'(st16()), 32'(ST_DIV));
        repeat (15) tick();
        chk("div_still", 32'(st16()), 32'(ST_DIV));
        chk("div_done_lo", 32'(bus16.Done), 32'h0);
        tick();
        chk("div_state_done", 32'(st16()), 32'(ST_DONE));
        chk("div_c",    32'(bus16.C), 32'd14);
        chk("div_r",    32'(bus16.R), 32'd2);
        chk("div_flag", 32'(bus16.Flag), 32'h0);

        // Chain: 14 + 3
        press16(BU, 16'h0000);
        chk("chain_gb", 32'(st16()), 32'(ST_GB));
        press16(BR, 16'd3);
        press16(BR, 16'h0000);
        tick();
        chk("chain_c",    32'(bus16.C), 32'd17);
        chk("chain_flag", 32'(bus16.Flag), 32'h0);
        chk("chain_r",    32'(bus16.R), 32'h0);

        // Chain into division, then abort with Reset mid-iteration
        press16(BU, 16'h0000);
        press16(BR, 16'd3);
        press16(BR, 16'h0003);
        repeat (6) tick();
        chk("abort_mid_state", 32'(st16()), 32'(ST_DIV));
        chk("abort_c_stable",  32'(bus16.C), 32'd17);
        #2 Reset = 1'b1;
        #1;
        chk("abort_state", 32'(st16()), 32'(ST_I));
        chk("abort_c",     32'(bus16.C), 32'h0);
        chk("abort_r",     32'(bus16.R), 32'h0);
        chk("abort_flag",  32'(bus16.Flag), 32'h0);
        chk("abort_done",  32'(bus16.Done), 32'h0);
        #1 Reset = 1'b0;

        // Subtract with borrow: 3 - 5
        press16(BU, 16'h0000);
        press16(BR, 16'h0003);
        press16(BR, 16'h0005);
        press16(BR, 16'h0001);
        chk("sub_state", 32'(st16()), 32'(ST_SUB));
        tick();
        chk("sub_c",    32'(bus16.C), 32'hFFFE);
        chk("sub_flag", 32'(bus16.Flag), 32'h1);
        chk("sub_r",    32'(bus16.R), 32'h0);

        // Divide by zero
        press16(BL, 16'h0000);
        press16(BU, 16'h0000);
        press16(BR, 16'h0005);
        press16(BR, 16'h0000);
        press16(BR, 16'h0003);
        chk("dz_state", 32'(st16()), 32'(ST_ERR));
        chk("dz_c",     32'(bus16.C), 32'hFFFF);
        chk("dz_r",     32'(bus16.R), 32'h0005);
        chk("dz_flag",  32'(bus16.Flag), 32'h1);
        chk("dz_done",  32'(bus16.Done), 32'h1);
        press16(BU, 16'h0000);
        chk("dz_no_chain", 32'(st16()), 32'(ST_ERR));
        press16(BL, 16'h0000);
        chk("dz_ack", 32'(st16()), 32'(ST_I));
        chk("dz_c_held", 32'(bus16.C), 32'hFFFF);

        // Button priority and step-back
        press16(BU, 16'h0000);
        chk("prio_clr_c", 32'(bus16.C), 32'h0);
        press16(BU | BR, 16'h1234);
        chk("prio_u_over_r", 32'(st16()), 32'(ST_GA));
        press16(BR, 16'h0020);
        press16(BL | BR, 16'h0040);
        chk("prio_l_over_r", 32'(st16()), 32'(ST_I));
        press16(BU, 16'h0000);
        press16(BR, 16'h0020);
        press16(BR, 16'h0009);
        chk("back_go", 32'(st16()), 32'(ST_GO));
        press16(BD, 16'h0001);
        chk("back_gb", 32'(st16()), 32'(ST_GB));
        press16(BR, 16'h0009);
        press16(BR, 16'h0000);
        tick();
        chk("back_add_c", 32'(bus16.C), 32'h0029);

        // 8-bit multiply with overflow: 0x10 * 0x20
        press8(BU, 8'h00);
        press8(BR, 8'h10);
        press8(BR, 8'h20);
        press8(BR, 8'h02);
        chk("mul1_state", 32'(st8()), 32'(ST_MUL));
        repeat (7) tick();
        chk("mul1_still", 32'(st8()), 32'(ST_MUL));
        chk("mul1_done_lo", 32'(bus8.Done), 32'h0);
        tick();
        chk("mul1_done", 32'(bus8.Done), 32'h1);
        chk("mul1_c",    32'(bus8.C), 32'h00);
        chk("mul1_flag", 32'(bus8.Flag), 32'h1);
        chk("mul1_r",    32'(bus8.R), 32'h0);

        // 8-bit multiply without overflow: 0x0F * 0x11
        press8(BL, 8'h00);
        press8(BU, 8'h00);
        press8(BR, 8'h0F);
        press8(BR, 8'h11);
        press8(BR, 8'h02);
        repeat (4) tick();
        chk("mul2_c_stable", 32'(bus8.C), 32'h00);
        repeat (3) tick();
        chk("mul2_still", 32'(st8()), 32'(ST_MUL));
        tick();
        chk("mul2_state", 32'(st8()), 32'(ST_DONE));
        chk("mul2_c",     32'(bus8.C), 32'hFF);
        chk("mul2_flag",  32'(bus8.Flag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
